// File: rtl/sha_msg_driver_pkg.sv
// Shared defaults and FSM state encoding for the SHA message front end.
package sha_msg_driver_pkg;

    localparam int NB_DEF = 64;
    localparam int NL_DEF = 8;
    localparam int NK_DEF = 256;
    localparam int LW_DEF = 64;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        PAD   = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_e;

endpackage

// File: rtl/sha_msg_driver_if.sv
// Byte-stream input, core block handshake and digest output of the message driver.
interface sha_msg_driver_if #(
    parameter int NB = 64,
    parameter int NK = 256
);
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          in_last;
    logic [7:0]    Data [0:NB-1];
    logic          Enable;
    logic          Init;
    logic [NK-1:0] Hash;
    logic          Ready;
    logic [NK-1:0] hash_out;
    logic          hash_valid;

    modport master (
        input  in_valid, in_data, in_last, Hash, Ready,
        output in_ready, Data, Enable, Init, hash_out, hash_valid
    );

    modport slave (
        output in_valid, in_data, in_last, Hash, Ready,
        input  in_ready, Data, Enable, Init, hash_out, hash_valid
    );
endinterface

// File: rtl/sha_msg_driver_pad.sv
// Combinational padding of one block: places the 0x80 marker and, when it
// still fits, the big-endian bit length in the last NL bytes.
module sha_msg_driver_pad #(
    parameter int NB = 64,
    parameter int NL = 8,
    parameter int LW = 64,
    parameter int IW = 7
) (
    input  logic [7:0]    blk_i [NB],
    input  logic [IW-1:0] idx_i,
    input  logic          pad80_done_i,
    input  logic [LW-1:0] bitlen_i,
    output logic [7:0]    blk_o [NB],
    output logic          final_o,
    output logic          pad80_done_o
);
    localparam int LEN_START = NB - NL;
    localparam int LW_BYTES  = LW / 8;

    logic          put_80;
    logic [IW-1:0] free_pos;

    // A completely full block (idx == NB) gets no marker; it moves to the next block.
    assign put_80       = !pad80_done_i && (idx_i < IW'(NB));
    assign free_pos     = put_80 ? idx_i + IW'(1) : idx_i;
    assign final_o      = (free_pos <= IW'(LEN_START));
    assign pad80_done_o = pad80_done_i || put_80;

    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        localparam bit IS_LEN = (gi >= LEN_START);
        logic [7:0] len_byte;

        if (IS_LEN && ((NB - 1 - gi) < LW_BYTES)) begin : g_len
            assign len_byte = bitlen_i[8*(NB-1-gi) +: 8];
        end else begin : g_nolen
            assign len_byte = 8'h00;
        end

        assign blk_o[gi] = (put_80 && (idx_i == IW'(gi))) ? 8'h80 :
                           (final_o && IS_LEN)            ? len_byte :
                                                            blk_i[gi];
    end
endmodule

// File: rtl/sha_msg_driver.sv
// Byte-stream front end for the sha core: collects message bytes into blocks,
// applies SHA padding and sequences Enable/Init/Ready per block.
module sha_msg_driver
    import sha_msg_driver_pkg::*;
#(
    parameter int NB = NB_DEF,
    parameter int NL = NL_DEF,
    parameter int NK = NK_DEF,
    parameter int LW = LW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    sha_msg_driver_if.master bus
);
    localparam int IW = $clog2(NB + 1);
    localparam int AW = $clog2(NB);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [LW-1:0] bitlen_q, bitlen_d;
    logic [7:0]    blk_q [NB];
    logic [7:0]    blk_d [NB];
    logic          first_q, first_d;
    logic          msg_end_q, msg_end_d;
    logic          pad80_done_q, pad80_done_d;
    logic          final_q, final_d;
    logic [NK-1:0] hash_out_q, hash_out_d;
    logic          hash_valid_q, hash_valid_d;

    logic [7:0]    pad_blk [NB];
    logic          pad_final;
    logic          pad_80;

    sha_msg_driver_pad #(
        .NB(NB),
        .NL(NL),
        .LW(LW),
        .IW(IW)
    ) u_pad (
        .blk_i       (blk_q),
        .idx_i       (idx_q),
        .pad80_done_i(pad80_done_q),
        .bitlen_i    (bitlen_q),
        .blk_o       (pad_blk),
        .final_o     (pad_final),
        .pad80_done_o(pad_80)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            idx_q        <= '0;
            bitlen_q     <= '0;
            blk_q        <= '{default: 8'h00};
            first_q      <= 1'b1;
            msg_end_q    <= 1'b0;
            pad80_done_q <= 1'b0;
            final_q      <= 1'b0;
            hash_out_q   <= '0;
            hash_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bitlen_q     <= bitlen_d;
            blk_q        <= blk_d;
            first_q      <= first_d;
            msg_end_q    <= msg_end_d;
            pad80_done_q <= pad80_done_d;
            final_q      <= final_d;
            hash_out_q   <= hash_out_d;
            hash_valid_q <= hash_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bitlen_d     = bitlen_q;
        blk_d        = blk_q;
        first_d      = first_q;
        msg_end_d    = msg_end_q;
        pad80_done_d = pad80_done_q;
        final_d      = final_q;
        hash_out_d   = hash_out_q;
        hash_valid_d = 1'b0;
        unique case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    blk_d[idx_q[AW-1:0]] = bus.in_data;
                    bitlen_d             = bitlen_q + LW'(8);
                    idx_d                = idx_q + IW'(1);
                    if (bus.in_last) begin
                        msg_end_d = 1'b1;
                        state_d   = PAD;
                    end else if (idx_q == IW'(NB - 1)) begin
                        final_d = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            PAD: begin
                blk_d        = pad_blk;
                pad80_done_d = pad_80;
                final_d      = pad_final;
                state_d      = ISSUE;
            end
            ISSUE: begin
                first_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                // Ready is only honoured here, never in the ISSUE cycle.
                if (bus.Ready) begin
                    blk_d = '{default: 8'h00};
                    idx_d = '0;
                    if (final_q) begin
                        hash_out_d   = bus.Hash;
                        hash_valid_d = 1'b1;
                        first_d      = 1'b1;
                        bitlen_d     = '0;
                        msg_end_d    = 1'b0;
                        pad80_done_d = 1'b0;
                        state_d      = FILL;
                    end else begin
                        state_d = msg_end_q ? PAD : FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign bus.in_ready   = (state_q == FILL);
    assign bus.Enable     = (state_q == ISSUE);
    assign bus.Init       = (state_q == ISSUE) && first_q;
    assign bus.Data       = blk_q;
    assign bus.hash_out   = hash_out_q;
    assign bus.hash_valid = hash_valid_q;
endmodule

// File: tb/tb_sha_msg_driver.sv
// Bench for sha_msg_driver: a SHA-256 core model answers each block, and a
// textbook padding reference predicts every block, Init flag and digest.
module tb_sha_msg_driver;
    localparam int NB = 64;
    localparam int NL = 8;
    localparam int NK = 256;
    localparam int LW = 64;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha_msg_driver_if #(.NB(NB), .NK(NK)) bus ();

    sha_msg_driver #(
        .NB(NB),
        .NL(NL),
        .NK(NK),
        .LW(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } sbyte_t;

    typedef struct {
        int len;
        int seed;
        int dly;
        int exp_blocks;
    } vec_t;

    int           checks = 0;
    int           errors = 0;
    sbyte_t       stim_q[$];
    logic [511:0] ref_blk_q[$];
    logic         ref_init_q[$];
    logic [255:0] ref_hash_q[$];
    logic [511:0] got_blk_q[$];
    logic         got_init_q[$];
    logic [255:0] got_hash_q[$];
    int           ready_dly;
    int           cnt;
    logic [255:0] core_h;
    bit           abort;
    vec_t         vecs[8];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h_in, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = h_in;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h_in[255:224] + a, h_in[223:192] + b, h_in[191:160] + c, h_in[159:128] + d,
                h_in[127:96] + e, h_in[95:64] + f, h_in[63:32] + g, h_in[31:0] + h};
    endfunction

    function automatic logic [511:0] pack_data();
        logic [511:0] p;
        for (int i = 0; i < NB; i++) p[511-8*i -: 8] = bus.Data[i];
        return p;
    endfunction

    function automatic logic [7:0] msg_byte(input int seed, input int k);
        if (seed == 0) return 8'(8'h61 + k);
        return 8'(seed * 37 + k * 11 + 5);
    endfunction

    function automatic logic [7:0] gb(input int b, input int i);
        logic [511:0] blk;
        if (b >= got_blk_q.size()) return 8'hxx;
        blk = got_blk_q[b];
        return blk[511-8*i -: 8];
    endfunction

    // Core model: compress on Enable, answer with Ready ready_dly cycles later.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            bus.Ready <= 1'b0;
            bus.Hash  <= '0;
            cnt       <= 0;
        end else begin
            bus.Ready <= 1'b0;
            if (bus.Enable) begin
                got_blk_q.push_back(pack_data());
                got_init_q.push_back(bus.Init);
                core_h <= sha_compress(bus.Init ? IV : core_h, pack_data());
                cnt    <= ready_dly;
            end else if (cnt == 1) begin
                bus.Ready <= 1'b1;
                bus.Hash  <= core_h;
                cnt       <= 0;
            end else if (cnt > 1) begin
                cnt <= cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst && bus.hash_valid) got_hash_q.push_back(bus.hash_out);
    end

    task automatic clear_all();
        stim_q.delete(); ref_blk_q.delete(); ref_init_q.delete(); ref_hash_q.delete();
        got_blk_q.delete(); got_init_q.delete(); got_hash_q.delete();
    endtask

    task automatic add_msg(input int len, input int seed);
        logic [7:0]   p[$];
        logic [511:0] b;
        logic [255:0] h;
        logic [63:0]  bits;
        for (int k = 0; k < len; k++) begin
            p.push_back(msg_byte(seed, k));
            stim_q.push_back('{d: msg_byte(seed, k), last: (k == len - 1)});
        end
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(len) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
        h = IV;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int i = 0; i < 64; i++) b[511-8*i -: 8] = p[bi*64+i];
            ref_blk_q.push_back(b);
            ref_init_q.push_back(bi == 0);
            h = sha_compress(h, b);
        end
        ref_hash_q.push_back(h);
    endtask

    task automatic drive_stim();
        int i = 0;
        int guard = 0;
        while (i < stim_q.size() && !abort && guard < 20000) begin
            @(negedge clk);
            guard++;
            bus.in_valid = 1'b1;
            bus.in_data  = stim_q[i].d;
            bus.in_last  = stim_q[i].last;
            if (bus.in_ready) i++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_and_check(input string name, input int exp_blocks);
        int c = 0;
        fork
            drive_stim();
        join_none
        while (got_hash_q.size() < ref_hash_q.size() && c < 5000) begin
            @(negedge clk);
            c++;
        end
        repeat (30) @(negedge clk);
        chk($sformatf("%s enables", name), got_blk_q.size(), exp_blocks);
        chk($sformatf("%s hash_count", name), got_hash_q.size(), ref_hash_q.size());
        for (int b = 0; b < ref_blk_q.size() && b < got_blk_q.size(); b++) begin
            chk($sformatf("%s blk%0d", name, b), got_blk_q[b], ref_blk_q[b]);
            chk($sformatf("%s init%0d", name, b), got_init_q[b], ref_init_q[b]);
        end
        for (int n = 0; n < ref_hash_q.size() && n < got_hash_q.size(); n++)
            chk($sformatf("%s hash%0d", name, n), got_hash_q[n], ref_hash_q[n]);
        $display("case %s: blocks %0d hashes %0d", name, got_blk_q.size(), got_hash_q.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b0; abort = 1'b0; ready_dly = 1;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset Enable", bus.Enable, 0);
        chk("reset Init", bus.Init, 0);
        chk("reset hash_valid", bus.hash_valid, 0);
        chk("reset hash_out", bus.hash_out, 0);
        chk("reset Data", pack_data(), 0);

        vecs = '{'{3, 0, 4, 1}, '{55, 5, 3, 1}, '{56, 9, 2, 2}, '{64, 17, 6, 2},
                 '{1, 33, 1, 1}, '{119, 2, 5, 2}, '{120, 7, 3, 3}, '{128, 11, 2, 3}};
        for (int v = 0; v < 8; v++) begin
            clear_all();
            ready_dly = vecs[v].dly;
            add_msg(vecs[v].len, vecs[v].seed);
            run_and_check($sformatf("vec%0d_len%0d", v, vecs[v].len), vecs[v].exp_blocks);
            case (vecs[v].len)
                3: begin
                    chk("abc byte0", gb(0, 0), 8'h61);
                    chk("abc byte3", gb(0, 3), 8'h80);
                    chk("abc byte63", gb(0, 63), 8'h18);
                    chk("abc digest", (got_hash_q.size() > 0) ? got_hash_q[0] : '0, ABC_DIGEST);
                end
                55: begin
                    chk("len55 byte55", gb(0, 55), 8'h80);
                    chk("len55 length", {gb(0, 56), gb(0, 62), gb(0, 63)}, 24'h0001B8);
                end
                56: begin
                    chk("len56 b0 byte56", gb(0, 56), 8'h80);
                    chk("len56 b0 byte63", gb(0, 63), 8'h00);
                    chk("len56 b1 length", {gb(1, 0), gb(1, 62), gb(1, 63)}, 24'h0001C0);
                end
                64: begin
                    chk("len64 b1 byte0", gb(1, 0), 8'h80);
                    chk("len64 b1 length", {gb(1, 62), gb(1, 63)}, 16'h0200);
                end
                default: ;
            endcase
        end

        clear_all();
        ready_dly = 80;
        add_msg(70, 3);
        add_msg(70, 4);
        add_msg(70, 5);
        run_and_check("b2b_3x70", 6);

        clear_all();
        ready_dly = 60;
        add_msg(100, 21);
        fork
            drive_stim();
        join_none
        c = 0;
        while (got_blk_q.size() < 1 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("rst first enable", got_blk_q.size(), 1);
        repeat (5) @(negedge clk);
        chk("rst in_ready in WAIT", bus.in_ready, 0);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst Enable low", bus.Enable, 0);
        chk("rst hash_out cleared", bus.hash_out, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst in_ready after release", bus.in_ready, 1);
        repeat (100) @(negedge clk);
        chk("rst no further enable", got_blk_q.size(), 1);
        chk("rst no hash_valid", got_hash_q.size(), 0);
        $display("case reset_in_wait: blocks %0d hashes %0d", got_blk_q.size(), got_hash_q.size());

        abort = 1'b0;
        clear_all();
        ready_dly = 3;
        add_msg(3, 0);
        run_and_check("abc_after_rst", 1);
        chk("abc_after_rst init", (got_init_q.size() > 0) ? got_init_q[0] : 1'b0, 1);
        chk("abc_after_rst digest", (got_hash_q.size() > 0) ? got_hash_q[0] : '0, ABC_DIGEST);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
